// File: rtl/riscv_lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer.
//   - FUNCT3_MEM_* : RISC-V load/store funct3 encodings (stores reuse the
//                    low-two-bit size field: SB=LB, SH=LH, SW=LW)
//   - lsu_state_e  : sequencer FSM state encoding
//   - LSU_ERR_*    : completion error codes reported on o_lsu_err
package riscv_lsu_ctrl_pkg;

  localparam logic [2:0] FUNCT3_MEM_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_MEM_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_MEM_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_MEM_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_MEM_LHU = 3'b101;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_REQ  = 2'd1,
    LSU_ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] LSU_ERR_OK       = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b11;

endpackage

// File: rtl/riscv_lsu_ctrl_align.sv
// Combinational lane logic for the load/store sequencer.
// Ports:
//   funct3_i    : access funct3 (size + signedness)
//   addr_lo_i   : byte offset within the word (addr[1:0])
//   wdata_i     : raw store data (rs2)
//   rdata_i     : raw bus read word
//   be_o        : byte enables for the access
//   wdata_o     : store data replicated across the lanes
//   illegal_o   : funct3 is not a valid load/store size
//   misalign_o  : legal size, but address not naturally aligned
//   rdata_o     : read word shifted down and sign/zero-extended
module riscv_lsu_ctrl_align
  import riscv_lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    illegal_o  = 1'b0;
    misalign_o = 1'b0;
    rdata_o    = 32'd0;
    // Addressed byte/half is moved down to lane 0 before extension.
    shifted    = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      FUNCT3_MEM_LB, FUNCT3_MEM_LBU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (funct3_i == FUNCT3_MEM_LB) ? {{24{shifted[7]}}, shifted[7:0]}
                                              : {24'd0, shifted[7:0]};
      end
      FUNCT3_MEM_LH, FUNCT3_MEM_LHU: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
        rdata_o    = (funct3_i == FUNCT3_MEM_LH) ? {{16{shifted[15]}}, shifted[15:0]}
                                                 : {16'd0, shifted[15:0]};
      end
      FUNCT3_MEM_LW: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = |addr_lo_i;
        rdata_o    = shifted;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a handshaked data bus.
// Accepts one access from the MEM stage, issues one word-aligned bus
// transaction (or rejects it with an error), stalls the pipeline until it
// completes and returns extended load data with a one-cycle done pulse.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_lsu_*               : access from MEM stage (held until o_lsu_done)
//   o_lsu_stall           : freeze pipeline
//   o_lsu_done/rdata/err  : completion pulse with load data and error code
//   o_dmem_*/i_dmem_*     : data bus request side and ack/read data
//   o_dbg_state           : current FSM state (lsu_state_e encoding)
// Handshake: o_dmem_req rises in the first REQ cycle and stays high with
// constant addr/be/we/wdata until the cycle i_dmem_ack is sampled high (or
// the timeout fires); it is low in the following cycle. i_dmem_rdata is
// only sampled in the ack cycle.
module riscv_lsu_ctrl
  import riscv_lsu_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lsu_valid,
  input  logic            i_lsu_wr_en,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  output logic            o_lsu_stall,
  output logic            o_lsu_done,
  output logic [XLEN-1:0] o_lsu_rdata,
  output logic [1:0]      o_lsu_err,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic [1:0]      o_dbg_state
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]      al_funct3;
  logic [1:0]      al_addr_lo;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_illegal;
  logic            al_misalign;
  logic            timeout;

  // One lane unit serves both phases: live inputs while deciding in IDLE,
  // the registered copy while extending the read word in REQ.
  assign al_funct3  = (state_q == LSU_ST_IDLE) ? i_lsu_funct3    : funct3_q;
  assign al_addr_lo = (state_q == LSU_ST_IDLE) ? i_lsu_addr[1:0] : addr_q[1:0];

  riscv_lsu_ctrl_align u_align (
    .funct3_i   (al_funct3),
    .addr_lo_i  (al_addr_lo),
    .wdata_i    (i_lsu_wdata),
    .rdata_i    (i_dmem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .illegal_o  (al_illegal),
    .misalign_o (al_misalign),
    .rdata_o    (al_rdata)
  );

  assign timeout = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= LSU_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_ST_IDLE: begin
        if (i_lsu_valid) begin
          state_d = (al_illegal || al_misalign) ? LSU_ST_RESP : LSU_ST_REQ;
        end
      end
      LSU_ST_REQ: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (i_dmem_ack || timeout) begin
          state_d = LSU_ST_RESP;
        end
      end
      LSU_ST_RESP: state_d = LSU_ST_IDLE;
      default:     state_d = LSU_ST_IDLE;
    endcase
  end

  // Datapath next-state: registered bus fields, result and wait counter
  always_comb begin
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      LSU_ST_IDLE: begin
        if (i_lsu_valid) begin
          addr_d   = i_lsu_addr;
          funct3_d = i_lsu_funct3;
          we_d     = i_lsu_wr_en;
          be_d     = al_be;
          wdata_d  = al_wdata;
          rdata_d  = '0;
          cnt_d    = '0;
          if (al_illegal) begin
            err_d = LSU_ERR_ILLEGAL;
          end else if (al_misalign) begin
            err_d = LSU_ERR_MISALIGN;
          end else begin
            err_d = LSU_ERR_OK;
          end
        end
      end
      LSU_ST_REQ: begin
        if (i_dmem_ack) begin
          rdata_d = we_q ? '0 : al_rdata;
          err_d   = LSU_ERR_OK;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = LSU_ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output logic: bus fields are only driven while requesting, results
  // only while done pulses.
  always_comb begin
    o_lsu_done   = 1'b0;
    o_lsu_rdata  = '0;
    o_lsu_err    = 2'b00;
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_be    = 4'b0000;
    o_dmem_wdata = '0;
    case (state_q)
      LSU_ST_REQ: begin
        o_dmem_req   = 1'b1;
        o_dmem_we    = we_q;
        o_dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
        o_dmem_be    = be_q;
        o_dmem_wdata = wdata_q;
      end
      LSU_ST_RESP: begin
        o_lsu_done  = 1'b1;
        o_lsu_rdata = rdata_q;
        o_lsu_err   = err_q;
      end
      default: ;
    endcase
  end

  // Stall is combinational on valid so the pipeline freezes the same cycle
  // the access appears; forced low while reset is held.
  assign o_lsu_stall = i_lsu_valid && !i_rst && (state_q != LSU_ST_RESP);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
module tb_riscv_lsu_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_lsu_valid;
  logic        i_lsu_wr_en;
  logic [2:0]  i_lsu_funct3;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic        o_lsu_stall;
  logic        o_lsu_done;
  logic [31:0] o_lsu_rdata;
  logic [1:0]  o_lsu_err;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // expected completion {err, rdata}
  logic [33:0] exp_q[$];

  riscv_lsu_ctrl #(.XLEN(32), .TIMEOUT_CYC(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lsu_valid  (i_lsu_valid),
    .i_lsu_wr_en  (i_lsu_wr_en),
    .i_lsu_funct3 (i_lsu_funct3),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_wdata  (i_lsu_wdata),
    .o_lsu_stall  (o_lsu_stall),
    .o_lsu_done   (o_lsu_done),
    .o_lsu_rdata  (o_lsu_rdata),
    .o_lsu_err    (o_lsu_err),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_be    (o_dmem_be),
    .o_dmem_wdata (o_dmem_wdata),
    .i_dmem_ack   (i_dmem_ack),
    .i_dmem_rdata (i_dmem_rdata),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   ref_be = 4'b0001 << lo;
      2'b01:   ref_be = lo[1] ? 4'b1100 : 4'b0011;
      default: ref_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   ref_wdata = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   ref_wdata = {wd[15:0], wd[15:0]};
      default: ref_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int sh;
    sh = int'(lo) * 8;
    b  = w[sh +: 8];
    h  = (lo[1]) ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  ref_load = {{24{b[7]}}, b};
      3'b100:  ref_load = {24'd0, b};
      3'b001:  ref_load = {{16{h[15]}}, h};
      3'b101:  ref_load = {16'd0, h};
      default: ref_load = w;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Presents one access, plays the bus (ack after ack_dly REQ cycles, -1 =
  // never) and checks bus fields, latency, stall and the scoreboard result.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int ack_dly, input logic [31:0] bus_rd,
                           input string name);
    logic        illegal, mis;
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    logic [33:0] e;
    int e_req_n, e_done_cyc, cyc, req_n;
    bit done_seen, bus_ok, stall_ok;

    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    mis     = !illegal && (((f3[1:0] == 2'b01) && addr[0]) ||
                           ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
    if (illegal) begin
      e_err = 2'b11; e_rd = 32'd0; e_req_n = 0; e_done_cyc = 1;
    end else if (mis) begin
      e_err = 2'b01; e_rd = 32'd0; e_req_n = 0; e_done_cyc = 1;
    end else if (ack_dly < 0 || ack_dly > 15) begin
      e_err = 2'b10; e_rd = 32'd0; e_req_n = 16; e_done_cyc = 17;
    end else begin
      e_err = 2'b00; e_rd = we ? 32'd0 : ref_load(f3, addr[1:0], bus_rd);
      e_req_n = ack_dly + 1; e_done_cyc = ack_dly + 2;
    end
    exp_q.push_back({e_err, e_rd});

    @(negedge i_clk);
    i_lsu_valid  = 1'b1;
    i_lsu_wr_en  = we;
    i_lsu_funct3 = f3;
    i_lsu_addr   = addr;
    i_lsu_wdata  = wd;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'd0;
    cyc = 0; req_n = 0; done_seen = 0; bus_ok = 1; stall_ok = 1;
    #1;
    n_checks++;
    if (o_lsu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_done: got %b want 0", name, o_lsu_done);
    end
    while (!done_seen && cyc < 64) begin
      if (o_lsu_done === 1'b1) begin
        done_seen = 1;
      end else begin
        if (o_lsu_stall !== 1'b1) stall_ok = 0;
        if (o_dmem_req === 1'b1) begin
          if (o_dmem_addr !== {addr[31:2], 2'b00} || o_dmem_be !== ref_be(f3, addr[1:0]) ||
              o_dmem_we !== we || o_dmem_wdata !== ref_wdata(f3, wd)) begin
            if (bus_ok)
              $display("FAIL %s bus: addr=%h be=%b we=%b wd=%h want addr=%h be=%b we=%b wd=%h",
                       name, o_dmem_addr, o_dmem_be, o_dmem_we, o_dmem_wdata,
                       {addr[31:2], 2'b00}, ref_be(f3, addr[1:0]), we, ref_wdata(f3, wd));
            bus_ok = 0;
          end
          i_dmem_ack   = (req_n == ack_dly);
          i_dmem_rdata = bus_rd;
          req_n++;
        end else begin
          i_dmem_ack = 1'b0;
        end
        @(negedge i_clk);
        #1;
        cyc++;
      end
    end

    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      if (!bus_ok) n_fail++;
      n_checks++;
      if (cyc != e_done_cyc) begin
        n_fail++;
        $display("FAIL %s latency: done at cycle %0d want %0d", name, cyc, e_done_cyc);
      end
      n_checks++;
      if (req_n != e_req_n) begin
        n_fail++;
        $display("FAIL %s req_cycles: got %0d want %0d", name, req_n, e_req_n);
      end
      n_checks++;
      if (!stall_ok || o_lsu_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL %s stall: high_before_done=%0d at_done=%b want 1/0", name, stall_ok, o_lsu_stall);
      end
      n_checks++;
      e = exp_q.pop_front();
      if ({o_lsu_err, o_lsu_rdata} !== e) begin
        n_fail++;
        $display("FAIL %s result: err=%b rdata=%h want err=%b rdata=%h",
                 name, o_lsu_err, o_lsu_rdata, e[33:32], e[31:0]);
      end
    end
    i_lsu_valid = 1'b0;
    i_dmem_ack  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    i_lsu_valid = 1'b0; i_lsu_wr_en = 1'b0; i_lsu_funct3 = 3'd0;
    i_lsu_addr = 32'd0; i_lsu_wdata = 32'd0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
    repeat (2) @(negedge i_clk);
    #1;
    n_checks++;
    if ({o_lsu_stall, o_lsu_done, o_lsu_rdata, o_lsu_err, o_dmem_req, o_dmem_we,
         o_dmem_addr, o_dmem_be, o_dmem_wdata, o_dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b done=%b stall=%b state=%0d want all zero",
               o_dmem_req, o_lsu_done, o_lsu_stall, o_dbg_state);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_store_word();
    do_access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, "sw_0x100");
  endtask

  task automatic test_load_byte();
    do_access(1'b0, 3'b000, 32'h0000_0203, 32'h0, 0, 32'h80FF_FF7F, "lb_0x203");
    do_access(1'b0, 3'b100, 32'h0000_0203, 32'h0, 1, 32'h80FF_FF7F, "lbu_0x203");
  endtask

  task automatic test_half();
    do_access(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 0, 32'h0, "sh_0x102");
    do_access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 2, 32'h1234_5678, "lhu_0x102");
    do_access(1'b0, 3'b001, 32'h0000_0100, 32'h0, 0, 32'h1234_8765, "lh_0x100");
  endtask

  task automatic test_errors();
    do_access(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'hFFFF_FFFF, "lw_misalign");
    do_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'hFFFF_FFFF, "illegal_011");
    do_access(1'b1, 3'b001, 32'h0000_0103, 32'h5555, 0, 32'h0, "sh_misalign");
    do_access(1'b1, 3'b111, 32'h0000_0200, 32'h5555, 0, 32'h0, "illegal_111");
  endtask

  task automatic test_timeout();
    do_access(1'b0, 3'b010, 32'h0000_0200, 32'h0, -1, 32'hCAFE_F00D, "lw_timeout");
    do_access(1'b0, 3'b010, 32'h0000_0204, 32'h0, 15, 32'hCAFE_F00D, "lw_ack_last");
    do_access(1'b1, 3'b010, 32'h0000_0208, 32'h1111_2222, -1, 32'h0, "sw_timeout");
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    i_lsu_valid = 1'b1; i_lsu_wr_en = 1'b1; i_lsu_funct3 = 3'b010;
    i_lsu_addr = 32'h0000_0300; i_lsu_wdata = 32'h0BAD_F00D; i_dmem_ack = 1'b0;
    @(negedge i_clk);
    #1;
    n_checks++;
    if (o_dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: req=%b want 1", o_dmem_req);
    end
    i_rst = 1'b1;
    #1;
    n_checks++;
    if ({o_dmem_req, o_lsu_stall, o_lsu_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_mid: req=%b stall=%b done=%b want 0 0 0", o_dmem_req, o_lsu_stall, o_lsu_done);
    end
    @(negedge i_clk);
    i_lsu_valid = 1'b0;
    i_rst = 1'b0;
    do_access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0, "sw_after_rst");
  endtask

  task automatic test_back_to_back();
    logic [2:0] ld_f3 [5];
    logic [2:0] f3;
    logic       we;
    logic [31:0] a;
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
    ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      a  = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 2) != 0) begin
        // bias toward aligned so most accesses reach the bus
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      do_access(we, f3, a, $urandom, int'($urandom_range(0, 4)), $urandom, "b2b");
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_lsu_ctrl.md
Name: riscv_lsu_ctrl

Overview:
Load/store sequencer between the pipelined core's MEM stage and a handshaked data-memory bus. It takes the decoded memory-access signals (write enable, funct3, address, store data) and converts them into one aligned bus transaction. It stalls the pipeline until the transaction completes, then returns sign/zero-extended load data. Misaligned accesses, illegal funct3 values and bus timeouts are reported as error codes instead of being issued or left hanging.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT_CYC, 16, max cycles in REQ without ack before abort (>=2)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_lsu_valid  in  1  MEM stage holds a load/store; held stable until o_lsu_done
i_lsu_wr_en  in  1  1=store, 0=load
i_lsu_funct3  in  3  FUNCT3_MEM_* encoding
i_lsu_addr  in  XLEN  byte address
i_lsu_wdata  in  XLEN  store data (rs2)
o_lsu_stall  out  1  freeze pipeline
o_lsu_done  out  1  one-cycle completion pulse
o_lsu_rdata  out  XLEN  extended load data, valid with done
o_lsu_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid with done
o_dmem_req  out  1  bus request
o_dmem_we  out  1  bus write
o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
o_dmem_be  out  4  byte enables
o_dmem_wdata  out  XLEN  lane-replicated store data
i_dmem_ack  in  1  bus accept/complete, single-cycle
i_dmem_rdata  in  XLEN  read word, valid with ack

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; timeout counter 0.
- FSM states: IDLE, REQ, RESP.
- IDLE, i_lsu_valid=0: stay in IDLE.
- IDLE, valid and access legal: register the bus fields; next state REQ.
- IDLE, valid and illegal funct3 (3,6,7): no bus access; next state RESP with err=11.
- IDLE, valid and misaligned (half with addr[0]=1; word with addr[1:0]!=0): no bus access; next state RESP with err=01.
- REQ: o_dmem_req=1; address, be, we and wdata held constant from the registered copy.
  - ack=1: latch the extended read data; next state RESP with err=00.
  - counter reaches TIMEOUT_CYC-1 without ack: drop req; next state RESP with err=10, rdata=0.
  - ack and timeout in the same cycle: ack wins.
- RESP: o_lsu_done=1 for exactly one cycle; next state IDLE.
- o_lsu_stall = i_lsu_valid & (state!=RESP). It is combinational, so it rises in the same cycle valid is first seen.
- Latency: an access accepted in cycle 0 with ack in its first REQ cycle gives done in cycle 2, i.e. 2 stall cycles. Each extra wait cycle adds 1.
- A new access can be accepted in the cycle after RESP (back-to-back allowed).
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load data: word shifted right by {addr[1:0],3'b000}, then:
  - LB/LH: sign-extend
  - LBU/LHU: zero-extend
  - LW: pass through
- Stores and errored accesses: o_lsu_rdata=0.
- i_lsu_valid dropped while in REQ is a protocol violation. The bus transaction still completes and done still pulses.
- o_dmem_req never toggles mid-transaction; it deasserts in the cycle after ack.

Decomposition:
- Shared config header (riscv_configs.v): LSU_ST_IDLE/REQ/RESP encodings, LSU_ERR_OK/MISALIGN/TIMEOUT/ILLEGAL codes. Reuse the existing FUNCT3_MEM_* defines.
- One combinational sub-module, riscv_lsu_align: computes be, replicated wdata, misalign/illegal flags and extended rdata from funct3/addr.
- riscv_lsu_ctrl holds the FSM, the registers and the timeout counter.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, ack on first REQ cycle -> be=1111, addr=0x100, done in cycle 2, stall high for cycles 0-1, err=00.
- LB addr 0x203, rdata 0x80FF_FF7F -> be=1000, o_lsu_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x102, wdata 0x0000ABCD -> be=1100, wdata=0xABCDABCD. LHU addr 0x102 with rdata 0x1234_5678 -> 0x00001234.
- LW addr 0x101 -> no o_dmem_req, done at cycle 1, err=01. Funct3=3'b011 -> err=11, no bus access.
- Load with ack never asserted, TIMEOUT_CYC=16 -> req high exactly 16 cycles, then done with err=10, rdata=0. Ack arriving on cycle 16 -> err=00.
- Assert i_rst during REQ -> req, stall and done go 0 immediately; after release, a fresh SW completes normally.
